// File: rtl/reg_scoreboard.sv
// reg_scoreboard: register scoreboard for in-order issue.
//
// Each architectural register r1..r31 has a 2-bit count of in-flight writes.
// An instruction may issue when none of its sources has a pending write and
// its destination counter has room. Every cycle that a presented instruction
// cannot issue is counted in a saturating 16-bit stall counter.
//
// Ports:
//   clk            rising-edge clock
//   reset          synchronous, active-high reset
//   issue_valid    instruction presented for issue
//   issue_rs       first source register
//   issue_rt       second source register (used only when issue_uses_rt=1)
//   issue_uses_rt  issue_rt is a real source
//   issue_wr_en    presented instruction writes issue_dest
//   issue_dest     destination register
//   wb_en          writeback retires a write to wb_dest
//   wb_dest        writeback destination register
//   flush          discard all pending writes
//   issue_ready    presented instruction may issue this cycle
//   stall          issue_valid & ~issue_ready
//   stall_count    saturating count of stall cycles
//
// Build option:
//   SCOREBOARD_WB_BYPASS_EN  when defined, a source whose only pending write is
//                            being written back this cycle is not a hazard.

module reg_scoreboard (
  input  logic        clk,
  input  logic        reset,
  input  logic        issue_valid,
  input  logic [4:0]  issue_rs,
  input  logic [4:0]  issue_rt,
  input  logic        issue_uses_rt,
  input  logic        issue_wr_en,
  input  logic [4:0]  issue_dest,
  input  logic        wb_en,
  input  logic [4:0]  wb_dest,
  input  logic        flush,
  output logic        issue_ready,
  output logic        stall,
  output logic [15:0] stall_count
);

  logic [1:0]  pend_q [1:31];
  logic [1:0]  pend_d [1:31];
  logic [15:0] stall_count_q;
  logic [15:0] stall_count_d;

  // Full 32-entry view with r0 hard-wired to zero, so lookups by any
  // register number need no special case for r0.
  logic [1:0]  pend_all [0:31];

  logic        rs_busy;
  logic        rt_busy;
  logic        struct_haz;
  logic        issue_fire;
  logic        wb_fire;

  always_comb begin
    pend_all[0] = 2'd0;
    for (int r = 1; r < 32; r++) begin
      pend_all[r] = pend_q[r];
    end
  end

  assign wb_fire = wb_en && (wb_dest != 5'd0);

  always_comb begin
    rs_busy    = (issue_rs != 5'd0) && (pend_all[issue_rs] != 2'd0);
    rt_busy    = issue_uses_rt && (issue_rt != 5'd0) && (pend_all[issue_rt] != 2'd0);
`ifdef SCOREBOARD_WB_BYPASS_EN
    // The last outstanding write is retiring right now: its value is
    // available this cycle, so the source need not wait.
    if (wb_fire && (wb_dest == issue_rs) && (pend_all[issue_rs] == 2'd1)) begin
      rs_busy = 1'b0;
    end
    if (wb_fire && (wb_dest == issue_rt) && (pend_all[issue_rt] == 2'd1)) begin
      rt_busy = 1'b0;
    end
`endif
    struct_haz = issue_wr_en && (issue_dest != 5'd0) && (pend_all[issue_dest] == 2'd3);
  end

  assign issue_ready = !reset && !flush && (!issue_valid || !(rs_busy || rt_busy || struct_haz));
  assign stall       = !reset && issue_valid && !issue_ready;
  assign issue_fire  = issue_valid && issue_ready && issue_wr_en && (issue_dest != 5'd0);

  // Issue and writeback to the same register cancel. Increment cannot
  // overflow because a full counter blocks issue_ready; decrement holds at 0.
  always_comb begin
    for (int r = 1; r < 32; r++) begin
      pend_d[r] = pend_q[r];
      if (issue_fire && (issue_dest == 5'(r)) && !(wb_fire && (wb_dest == 5'(r)))) begin
        pend_d[r] = pend_q[r] + 2'd1;
      end else if (wb_fire && (wb_dest == 5'(r)) && !(issue_fire && (issue_dest == 5'(r)))
                   && (pend_q[r] != 2'd0)) begin
        pend_d[r] = pend_q[r] - 2'd1;
      end
    end
  end

  always_comb begin
    stall_count_d = stall_count_q;
    if (stall && (stall_count_q != 16'hFFFF)) begin
      stall_count_d = stall_count_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int r = 1; r < 32; r++) begin
        pend_q[r] <= 2'd0;
      end
      stall_count_q <= 16'd0;
    end else begin
      for (int r = 1; r < 32; r++) begin
        pend_q[r] <= flush ? 2'd0 : pend_d[r];
      end
      stall_count_q <= stall_count_d;
    end
  end

  assign stall_count = stall_count_q;

endmodule
